// File: rtl/keystream_xor_unit.sv
// Keystream XOR unit: packs the serial LFSR keystream LSB-first into DATA_W-bit key words,
// buffers them in a FIFO_DEPTH-entry FIFO and XORs each accepted data word with the oldest key.
// Optional: define KSX_DROP_CNT_EN to add the saturating o_drop_cnt discarded-bit counter.
module keystream_xor_unit #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                            i_clk,
    input  logic                            i_reset,
    input  logic                            i_keystream,
    input  logic                            i_ks_en,
    input  logic [DATA_W-1:0]               i_data,
    input  logic                            i_data_valid,
    output logic                            o_data_ready,
    output logic [DATA_W-1:0]               o_data,
    output logic                            o_data_valid,
    input  logic                            i_data_ready,
`ifdef KSX_DROP_CNT_EN
    output logic [15:0]                     o_drop_cnt,
`endif
    output logic [$clog2(FIFO_DEPTH):0]     o_key_level
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int BW = $clog2(DATA_W);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);
    localparam logic [LW-1:0] FULL_LVL = LW'(FIFO_DEPTH);

    logic [DATA_W-1:0] sh;
    logic [BW-1:0]     bcnt;
    logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [LW-1:0]     count;

    logic              full;
    logic              take;
    logic              push;
    logic              pop;
    logic [DATA_W-1:0] next_word;

    // Full is taken from the registered count only: a pop this cycle does not free a slot
    // for a bit arriving in the same cycle.
    assign full      = (count == FULL_LVL);
    assign take      = i_ks_en && !full;
    assign next_word = {i_keystream, sh[DATA_W-1:1]};
    assign push      = take && (bcnt == LAST_BIT);

    // Handshake: a word transfers on a cycle where valid and ready are both high. Input ready
    // depends only on registers and i_data_ready; o_data/o_data_valid stay stable while stalled.
    assign o_data_ready = (count != '0) && (!o_data_valid || i_data_ready);
    assign pop          = i_data_valid && o_data_ready;
    assign o_key_level  = count;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            sh   <= '0;
            bcnt <= '0;
        end else if (take) begin
            sh   <= next_word;
            bcnt <= push ? '0 : bcnt + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= next_word;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_data       <= '0;
            o_data_valid <= 1'b0;
        end else if (pop) begin
            o_data       <= i_data ^ fifo_mem[rd_ptr];
            o_data_valid <= 1'b1;
        end else if (i_data_ready) begin
            o_data_valid <= 1'b0;
        end
    end

`ifdef KSX_DROP_CNT_EN
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_drop_cnt <= '0;
        end else if (i_ks_en && full && (o_drop_cnt != 16'hFFFF)) begin
            o_drop_cnt <= o_drop_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_keystream_xor_unit.sv
// Bench for keystream_xor_unit: directed scenarios plus random traffic, every cycle compared
// against a bit/word queue reference model. Checks o_drop_cnt when KSX_DROP_CNT_EN is defined.
module tb_keystream_xor_unit;

    localparam int DATA_W     = 8;
    localparam int FIFO_DEPTH = 4;
    localparam int LW         = $clog2(FIFO_DEPTH) + 1;

    logic              clk;
    logic              i_reset;
    logic              i_keystream;
    logic              i_ks_en;
    logic [DATA_W-1:0] i_data;
    logic              i_data_valid;
    logic              o_data_ready;
    logic [DATA_W-1:0] o_data;
    logic              o_data_valid;
    logic              i_data_ready;
    logic [LW-1:0]     o_key_level;
`ifdef KSX_DROP_CNT_EN
    logic [15:0]       o_drop_cnt;
`endif

    keystream_xor_unit #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .i_clk        (clk),
        .i_reset      (i_reset),
        .i_keystream  (i_keystream),
        .i_ks_en      (i_ks_en),
        .i_data       (i_data),
        .i_data_valid (i_data_valid),
        .o_data_ready (o_data_ready),
        .o_data       (o_data),
        .o_data_valid (o_data_valid),
        .i_data_ready (i_data_ready),
`ifdef KSX_DROP_CNT_EN
        .o_drop_cnt   (o_drop_cnt),
`endif
        .o_key_level  (o_key_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: key words as a queue, partial word built bit by bit.
    logic [DATA_W-1:0] exp_q[$];
    logic [DATA_W-1:0] m_part;
    int                m_bits;
    logic              m_valid;
    logic [DATA_W-1:0] m_data;
    int                m_drop;

    int n_checks = 0;
    int n_fails  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        exp_q.delete();
        m_part  = '0;
        m_bits  = 0;
        m_valid = 1'b0;
        m_data  = '0;
        m_drop  = 0;
    endtask

    task automatic check_regs(input string tag);
        check({tag, "_level"}, 32'(o_key_level), 32'(exp_q.size()));
        check({tag, "_valid"}, 32'(o_data_valid), 32'(m_valid));
        check({tag, "_data"},  32'(o_data), 32'(m_data));
`ifdef KSX_DROP_CNT_EN
        check({tag, "_drop"},  32'(o_drop_cnt), 32'(m_drop));
`endif
    endtask

    task automatic do_reset();
        @(negedge clk);
        i_reset      = 1'b1;
        i_ks_en      = 1'b0;
        i_keystream  = 1'b0;
        i_data_valid = 1'b0;
        i_data       = '0;
        i_data_ready = 1'b1;
        @(posedge clk);
        #1;
        i_reset = 1'b0;
        model_clear();
        check_regs("reset");
        check("reset_ready", 32'(o_data_ready), 32'd0);
    endtask

    // One clock: drive, check combinational ready, clock, advance model, check registers.
    task automatic step(input logic ks_en, input logic ks_bit, input logic dv,
                        input logic [DATA_W-1:0] d, input logic dr);
        logic exp_ready;
        logic was_full;
        logic acc;
        @(negedge clk);
        i_ks_en      = ks_en;
        i_keystream  = ks_bit;
        i_data_valid = dv;
        i_data       = d;
        i_data_ready = dr;
        #1;
        was_full  = (exp_q.size() == FIFO_DEPTH);
        exp_ready = (exp_q.size() != 0) && (!m_valid || dr);
        check("ready", 32'(o_data_ready), 32'(exp_ready));
        acc = dv && exp_ready;
        @(posedge clk);
        if (acc) begin
            m_data  = d ^ exp_q.pop_front();
            m_valid = 1'b1;
        end else if (dr) begin
            m_valid = 1'b0;
        end
        if (ks_en) begin
            if (!was_full) begin
                m_part[m_bits] = ks_bit;
                m_bits++;
                if (m_bits == DATA_W) begin
                    exp_q.push_back(m_part);
                    m_part = '0;
                    m_bits = 0;
                end
            end else if (m_drop < 65535) begin
                m_drop++;
            end
        end
        #1;
        check_regs("step");
    endtask

    task automatic feed_bits(input int n, input logic dr);
        for (int i = 0; i < n; i++) step(1'b1, 1'($urandom_range(0, 1)), 1'b0, '0, dr);
    endtask

    logic [7:0] pattern;

    initial begin
        i_reset = 1'b1; i_ks_en = 1'b0; i_keystream = 1'b0;
        i_data_valid = 1'b0; i_data = '0; i_data_ready = 1'b1;
        model_clear();
        do_reset();

        // Packing order: 1,0,1,1,0,0,1,0 -> key 0x4D, 0xFF ^ 0x4D = 0xB2.
        pattern = 8'b0100_1101;
        for (int i = 0; i < 8; i++) step(1'b1, pattern[i], 1'b0, '0, 1'b1);
        check("pack_level", 32'(o_key_level), 32'd1);
        step(1'b0, 1'b0, 1'b1, 8'hFF, 1'b1);
        check("pack_data", 32'(o_data), 32'hB2);
        check("pack_valid", 32'(o_data_valid), 32'd1);
        step(1'b0, 1'b0, 1'b0, '0, 1'b1);

        // Fill to full, then 8 discarded bits; later drain to confirm the partial word survived.
        do_reset();
        feed_bits(32, 1'b1);
        check("full_level", 32'(o_key_level), 32'd4);
        feed_bits(8, 1'b1);
        check("full_hold", 32'(o_key_level), 32'd4);
`ifdef KSX_DROP_CNT_EN
        check("drop_8", 32'(o_drop_cnt), 32'd8);
`endif
        step(1'b1, 1'b1, 1'b1, 8'h3C, 1'b1);
        feed_bits(9, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1, 8'($urandom), 1'b1);

        // Back-pressure: two keys, sink stalled, two words offered.
        do_reset();
        feed_bits(16, 1'b0);
        step(1'b0, 1'b0, 1'b1, 8'hA5, 1'b0);
        step(1'b0, 1'b0, 1'b1, 8'h5A, 1'b0);
        step(1'b0, 1'b0, 1'b1, 8'h5A, 1'b0);
        check("bp_hold_valid", 32'(o_data_valid), 32'd1);
        step(1'b0, 1'b0, 1'b1, 8'h5A, 1'b1);
        check("bp_second_level", 32'(o_key_level), 32'd0);
        step(1'b0, 1'b0, 1'b0, '0, 1'b1);

        // Simultaneous push and pop with one key buffered.
        do_reset();
        feed_bits(15, 1'b1);
        step(1'b1, 1'b1, 1'b1, 8'hC3, 1'b1);
        check("pushpop_level", 32'(o_key_level), 32'd1);
        step(1'b0, 1'b0, 1'b1, 8'h81, 1'b1);

        // Reset mid-operation: 3 keys, 5 partial bits, stalled valid output.
        do_reset();
        feed_bits(32, 1'b0);
        step(1'b0, 1'b0, 1'b1, 8'h77, 1'b0);
        feed_bits(5, 1'b0);
        check("mid_level", 32'(o_key_level), 32'd3);
        do_reset();
        feed_bits(7, 1'b1);
        check("mid_not_ready", 32'(o_data_ready), 32'd0);
        feed_bits(1, 1'b1);

        // Empty FIFO: data waits for a key, accepted the cycle after the push.
        do_reset();
        for (int i = 0; i < 8; i++) step(1'b1, 1'($urandom_range(0, 1)), 1'b1, 8'h99, 1'b1);
        step(1'b0, 1'b0, 1'b1, 8'h99, 1'b1);
        check("empty_accept", 32'(o_data_valid), 32'd1);

        // Random traffic.
        do_reset();
        for (int i = 0; i < 600; i++) begin
            step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 2) != 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/keystream_xor_unit.md
# keystream_xor_unit

Downstream consumer of the 128-bit LFSR keystream bit. Packs the serial keystream into DATA_W-bit key words, buffers them in a small FIFO, and XORs each accepted input data word with the oldest key word, producing cipher or plain text on a registered valid/ready output. It sits between the LFSR and the byte-stream datapath, and decouples the free-running keystream from data back-pressure.

## Interface
- DATA_W, 8: width of data words and key words; range 2..32.
- FIFO_DEPTH, 4: key-word FIFO depth; power of two, minimum 2.
- i_clk  in  1  clock; all logic is on the rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_keystream  in  1  keystream bit from the LFSR.
- i_ks_en  in  1  i_keystream is valid this cycle.
- i_data  in  DATA_W  input data word.
- i_data_valid  in  1  i_data is valid.
- o_data_ready  out  1  the unit accepts i_data this cycle.
- o_data  out  DATA_W  i_data XOR key word, registered.
- o_data_valid  out  1  o_data is valid.
- i_data_ready  in  1  the sink accepts o_data.
- o_key_level  out  $clog2(FIFO_DEPTH)+1  number of key words in the FIFO.
- o_drop_cnt  out  16  count of discarded keystream bits; present only with KSX_DROP_CNT_EN.

## Operation
- Packer:
  - Shift register sh[DATA_W-1:0] and bit counter bcnt, both 0 after reset.
  - A bit is taken when i_ks_en=1 and the FIFO is not full. On a taken bit: sh <= {i_keystream, sh[DATA_W-1:1]} and bcnt increments.
  - When bcnt==DATA_W-1 and a bit is taken, {i_keystream, sh[DATA_W-1:1]} is pushed to the FIFO and bcnt wraps to 0.
  - Packing is LSB-first: the first received bit lands in key bit 0.
- Full FIFO:
  - With i_ks_en=1 and the FIFO full, the bit is discarded. sh and bcnt hold, so the partial word is kept.
  - Full is evaluated on the registered count. There is no push-on-pop look-ahead.
- FIFO: circular buffer with read/write pointers that wrap modulo FIFO_DEPTH.
  - o_key_level is the registered count.
  - Push and pop in the same cycle leaves the count unchanged.
- Datapath:
  - o_data_ready = (o_key_level != 0) && (!o_data_valid || i_data_ready). It is combinational from registers and i_data_ready.
  - Accept = i_data_valid && o_data_ready.
  - On accept: o_data <= i_data ^ fifo[rd_ptr], o_data_valid <= 1, and the head is popped.
  - Else, if i_data_ready=1: o_data_valid <= 0. o_data holds its last value.
  - A stalled output (o_data_valid=1, i_data_ready=0) holds o_data and o_data_valid stable.
- Empty FIFO: o_data_ready=0. A key word pushed in cycle N is usable from cycle N+1; there is no bypass.

## Timing
- Reset (synchronous, takes effect at the clock edge):
  - o_data_valid=0, o_data=0, o_key_level=0, o_data_ready=0, o_drop_cnt=0.
  - sh=0, bcnt=0, pointers=0.
  - Reset applied mid-operation discards partial words, buffered keys and pending output.
- Key availability: DATA_W taken bits, then 1 cycle until o_key_level increments and o_data_ready can assert.
- Data latency: 1 cycle from accept to o_data_valid.
- Throughput: 1 word per cycle while the FIFO has keys and the sink is ready. The sustained rate is bounded by the keystream rate, 1 word per DATA_W enabled cycles.

## Configuration
- KSX_DROP_CNT_EN defined:
  - o_drop_cnt exists. It increments by 1 for each discarded keystream bit (i_ks_en=1 while full) and saturates at 0xFFFF.
  - Reset clears it to 0.
- KSX_DROP_CNT_EN undefined: the port and counter are absent. Discard behaviour is otherwise identical.

## Test plan
- Packing order, DATA_W=8:
  - Stimulus: bits 1,0,1,1,0,0,1,0 with i_ks_en=1, then i_data=0xFF valid with i_data_ready=1.
  - Response: o_key_level=1; o_data=0xB2 (key 0x4D) one cycle after accept.
- Fill to full and drop:
  - Stimulus: 40 consecutive enabled bits with no data.
  - Response: o_key_level=4 after bit 32; bits 33..40 discarded, sh/bcnt unchanged; o_drop_cnt=8 (with macro).
- Back-pressure:
  - Stimulus: 2 keys buffered, i_data_ready=0, two data words offered.
  - Response: first accepted; o_data and o_data_valid hold; o_data_ready=0 until i_data_ready=1; then second accepted the same cycle.
- Simultaneous push and pop:
  - Stimulus: 8th key bit taken in the same cycle as a data accept with o_key_level=1.
  - Response: o_key_level stays 1; XOR uses the old head.
- Reset mid-operation:
  - Stimulus: reset asserted for 1 cycle with 3 keys buffered, bcnt=5, o_data_valid=1.
  - Response: next cycle all outputs 0 and o_key_level=0; 8 further bits are needed before o_data_ready asserts.
- Empty FIFO:
  - Stimulus: i_data_valid=1 with o_key_level=0.
  - Response: o_data_ready=0; no output until a key is pushed, then accept occurs one cycle later.
